// File: rtl/bars_compose_seq.sv
// Sequential mixed-radix digit composition: Horner-accumulates N_DIGITS digits MSB-first,
// reduces the result mod p by repeated subtraction, then offers it on a valid/ready output.
module bars_compose_seq #(
    parameter int                N_BITS        = 254,
    parameter logic [N_BITS-1:0] PRIME_MODULUS = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
    parameter int                N_DIGITS      = 27,
    parameter int                DIGIT_BITS    = 10,
    parameter int                ACC_BITS      = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIGIT_BITS-1:0] in_digit,
    input  logic [DIGIT_BITS-1:0] in_base,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_BITS-1:0]     out_value,
    output logic                  out_err
);

    localparam int PROD_BITS = ACC_BITS + DIGIT_BITS + 1;
    localparam int CNT_BITS  = $clog2(N_DIGITS + 1);

    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(N_DIGITS - 1);
    localparam logic [ACC_BITS-1:0] P_EXT    = ACC_BITS'(PRIME_MODULUS);

    localparam logic [1:0] ST_ACCUM  = 2'd0;
    localparam logic [1:0] ST_REDUCE = 2'd1;
    localparam logic [1:0] ST_OUT    = 2'd2;

    logic [1:0]          state_reg, state_next;
    logic [ACC_BITS-1:0] acc_reg, acc_next;
    logic [CNT_BITS-1:0] cnt_reg, cnt_next;
    logic                err_reg, err_next;

    logic [PROD_BITS-1:0] prod_full;
    logic                 prod_ovf;
    logic                 accept;

    // Product is kept wide enough that any bits above the accumulator flag overflow.
    assign prod_full = PROD_BITS'(acc_reg) * PROD_BITS'(in_base) + PROD_BITS'(in_digit);
    assign prod_ovf  = |prod_full[PROD_BITS-1:ACC_BITS];
    assign accept    = in_valid & in_ready;

    assign in_ready  = (state_reg == ST_ACCUM);
    assign out_valid = (state_reg == ST_OUT);
    assign out_value = out_valid ? acc_reg[N_BITS-1:0] : '0;
    assign out_err   = out_valid & err_reg;

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        case (state_reg)
            ST_ACCUM: begin
                if (accept) begin
                    cnt_next = cnt_reg + CNT_BITS'(1);
                    if (cnt_reg == '0) begin
                        acc_next = ACC_BITS'(in_digit);
                    end else if (in_base == '0) begin
                        // A zero radix cannot carry history; restart from this digit.
                        acc_next = ACC_BITS'(in_digit);
                        err_next = 1'b1;
                    end else begin
                        acc_next = prod_full[ACC_BITS-1:0];
                        if (prod_ovf || (in_digit >= in_base))
                            err_next = 1'b1;
                    end
                    if (cnt_reg == LAST_CNT) begin
                        cnt_next   = '0;
                        state_next = ST_REDUCE;
                    end
                end
            end
            ST_REDUCE: begin
                if (acc_reg >= P_EXT)
                    acc_next = acc_reg - P_EXT;
                else
                    state_next = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    acc_next   = '0;
                    err_next   = 1'b0;
                    state_next = ST_ACCUM;
                end
            end
            default: state_next = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_ACCUM;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

endmodule

// File: tb/tb_bars_compose_seq.sv
// Directed bench: small configuration (p=251, 3 digits of 4 bits) plus a few full-size
// 27-digit frames checked against a Horner-mod-p model.
module tb_bars_compose_seq;

    localparam logic [253:0] P_W = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // small configuration
    logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_err;
    logic [3:0] in_digit = '0, in_base = '0;
    logic [7:0] out_value;

    // default configuration
    logic         w_in_valid = 1'b0, w_in_ready, w_out_valid, w_out_ready = 1'b0, w_out_err;
    logic [9:0]   w_in_digit = '0, w_in_base = '0;
    logic [253:0] w_out_value;

    bars_compose_seq #(
        .N_BITS(8), .PRIME_MODULUS(8'd251), .N_DIGITS(3), .DIGIT_BITS(4), .ACC_BITS(10)
    ) dut_small (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_digit(in_digit), .in_base(in_base),
        .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value), .out_err(out_err)
    );

    bars_compose_seq dut_wide (
        .clk(clk), .rst(rst),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_digit(w_in_digit), .in_base(w_in_base),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_value(w_out_value), .out_err(w_out_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [3:0] d, input logic [3:0] b);
        int n;
        n = 0;
        in_valid = 1'b1; in_digit = d; in_base = b;
        while (!in_ready && n < 50) begin tick(); n++; end
        check("accept_timeout", 256'(n < 50), 256'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                              input logic [3:0] b1, input logic [3:0] b2, input int gap);
        send_beat(d0, 4'd0);
        repeat (gap) tick();
        send_beat(d1, b1);
        repeat (gap) tick();
        send_beat(d2, b2);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin tick(); lat++; end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic frame_check(input string tag, input logic [3:0] d0, input logic [3:0] d1,
                               input logic [3:0] d2, input logic [3:0] b1, input logic [3:0] b2,
                               input int gap, input logic [7:0] exp_val, input logic exp_err,
                               input int exp_lat);
        int lat;
        send_frame(d0, d1, d2, b1, b2, gap);
        wait_out(lat);
        $display("frame %s: value=%0d err=%0b latency=%0d", tag, out_value, out_err, lat);
        check({tag, "_lat"}, 256'(lat), 256'(exp_lat));
        check({tag, "_value"}, 256'(out_value), 256'(exp_val));
        check({tag, "_err"}, 256'(out_err), 256'(exp_err));
        handshake();
        check({tag, "_in_ready_after"}, 256'(in_ready), 256'd1);
        check({tag, "_out_valid_after"}, 256'(out_valid), 256'd0);
    endtask

    task automatic w_send_beat(input logic [9:0] d, input logic [9:0] b);
        int n;
        n = 0;
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
        w_in_valid = 1'b1; w_in_digit = d; w_in_base = b;
        while (!w_in_ready && n < 50) begin tick(); n++; end
        check("w_accept_timeout", 256'(n < 50), 256'd1);
        tick();
        w_in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0]   held;
        logic [9:0]   wd [27];
        logic [9:0]   wb [27];
        logic [511:0] m;
        logic         m_err;
        int           lat;

        repeat (3) tick();
        check("rst_in_ready", 256'(in_ready), 256'd1);
        check("rst_out_valid", 256'(out_valid), 256'd0);
        check("rst_out_value", 256'(out_value), 256'd0);
        check("rst_out_err", 256'(out_err), 256'd0);
        rst = 1'b0;
        tick();

        // 253 needs one subtraction; all-zero needs none
        frame_check("t1_253", 4'd2, 4'd5, 4'd3, 4'd10, 4'd10, 0, 8'd2, 1'b0, 2);
        frame_check("t2_zero", 4'd0, 4'd0, 4'd0, 4'd10, 4'd10, 0, 8'd0, 1'b0, 1);
        frame_check("t3_digit_ge_base", 4'd1, 4'd12, 4'd3, 4'd10, 4'd10, 0, 8'd223, 1'b1, 1);
        frame_check("t3_clean_after", 4'd0, 4'd0, 4'd7, 4'd10, 4'd10, 0, 8'd7, 1'b0, 1);
        // 3615 overflows 10 bits -> 543, then two subtractions -> 41
        frame_check("t_overflow", 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 0, 8'd41, 1'b1, 3);
        // zero radix restarts from the digit: 3*10+4=34
        frame_check("t_base_zero", 4'd5, 4'd3, 4'd4, 4'd0, 4'd10, 0, 8'd34, 1'b1, 1);
        frame_check("t_gaps", 4'd2, 4'd5, 4'd3, 4'd10, 4'd10, 3, 8'd2, 1'b0, 2);

        // output stall: value held, input blocked
        send_frame(4'd1, 4'd2, 4'd3, 4'd10, 4'd10, 0);
        wait_out(lat);
        check("t4_value", 256'(out_value), 256'd123);
        held = out_value;
        for (int i = 0; i < 5; i++) begin
            tick();
            $display("stall cycle %0d: value=%0d in_ready=%0b", i, out_value, in_ready);
            check("t4_stall_value", 256'(out_value), 256'(held));
            check("t4_stall_in_ready", 256'(in_ready), 256'd0);
        end
        handshake();
        check("t4_in_ready_next", 256'(in_ready), 256'd1);

        // reset mid-frame discards the partial frame
        send_beat(4'd4, 4'd0);
        send_beat(4'd6, 4'd10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_in_ready", 256'(in_ready), 256'd1);
        frame_check("t5_after_rst", 4'd0, 4'd0, 4'd9, 4'd10, 4'd10, 0, 8'd9, 1'b0, 1);

        // full-size frames; frame 0 is the largest value that fits (1023 then 699s in radix 700)
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 27; i++) begin
                if (f == 0) begin
                    wb[i] = 10'd700;
                    wd[i] = (i == 0) ? 10'd1023 : 10'd699;
                end else begin
                    wb[i] = 10'($urandom_range(600, 700));
                    wd[i] = (i == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, wb[i] - 1));
                end
            end
            if (f == 5) wd[13] = wb[13];
            m = 512'(wd[0]);
            m_err = 1'b0;
            for (int i = 1; i < 27; i++) begin
                m = (m * 512'(wb[i]) + 512'(wd[i])) % 512'(P_W);
                if (wd[i] >= wb[i]) m_err = 1'b1;
            end
            m = m % 512'(P_W);
            for (int i = 0; i < 27; i++) w_send_beat(wd[i], wb[i]);
            lat = 0;
            while (!w_out_valid && lat < 40) begin tick(); lat++; end
            check("w_out_timeout", 256'(lat < 40), 256'd1);
            repeat ($urandom_range(0, 3)) tick();
            $display("wide frame %0d: value=%0h err=%0b latency=%0d", f, w_out_value, w_out_err, lat);
            check("w_value", 256'(w_out_value), 256'(m[253:0]));
            check("w_err", 256'(w_out_err), 256'(m_err));
            w_out_ready = 1'b1;
            tick();
            w_out_ready = 1'b0;
            check("w_in_ready_after", 256'(w_in_ready), 256'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
